mem_access_unit: RTL
====================

# mem_access_unit

MEM-stage data-memory access controller, fed directly by the EX/MEM pipeline register, with its results consumed by the MEM/WB register.

- Decodes load/store size from the instruction held in EX/MEM.
- Runs a req/ack handshake to the data RAM bus, with byte-lane steering and load sign/zero extension.
- Stalls all upstream stages until the access completes.
- Flags misaligned, illegal-size and timed-out accesses without touching memory.

## Interface
- `TIMEOUT`, default 16: WAIT cycles without `bus_ack` before the access is abandoned (range 1..255).
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `mem_inst`  in  32  instruction in MEM. `[6:0]` is the opcode and `[14:12]` is funct3.
- `mem_alu_result`  in  32  effective byte address.
- `mem_rD2`  in  32  store data, right-aligned.
- `mem_DRAM_we`  in  1  store enable from control.
- `bus_req`  out  1  access request, registered.
- `bus_we`  out  1  1 = write, registered.
- `bus_addr`  out  32  `{addr[31:2],2'b00}`, registered.
- `bus_wstrb`  out  4  byte-lane write strobes, registered; `4'b0000` on reads.
- `bus_wdata`  out  32  lane-replicated store data, registered.
- `bus_rdata`  in  32  read word, sampled when `bus_ack`=1.
- `bus_ack`  in  1  completion, one-cycle pulse.
- `mem_stall`  out  1  combinational. Freezes PC, IF/ID, ID/EX and EX/MEM, and makes MEM/WB load a bubble.
- `mem_rdata`  out  32  extended load result, valid in DONE, 0 otherwise.
- `mem_misalign`  out  1  combinational; misaligned or illegal-size access.
- `mem_timeout`  out  1  registered; high only in DONE after a timeout.

## Operation
Access classification:
- Store: `mem_DRAM_we`=1.
- Load: opcode `7'b0000011` and `mem_DRAM_we`=0.
- Anything else: no access, `mem_stall`=0.

Size encoding (funct3):
- 000 = b, 001 = h, 010 = w, 100 = bu, 101 = hu.
- Loads accept all five; stores accept only 000/001/010.
- Any other code is illegal.

Bad access (illegal size, h/hu with `addr[0]`=1, or w with `addr[1:0]`≠0):
- `mem_misalign`=1 and `mem_stall`=0.
- No bus request; the store is suppressed and `mem_rdata`=0.
- Stays in IDLE.

Store steering:
- sb: `wstrb = 4'b0001<<addr[1:0]`, `wdata = {4{rD2[7:0]}}`.
- sh: `wstrb = addr[1] ? 4'b1100 : 4'b0011`, `wdata = {2{rD2[15:0]}}`.
- sw: `wstrb = 4'b1111`, `wdata = rD2`.

Load extraction is from the captured word:
- b/bu select the byte at `addr[1:0]`; h/hu select the halfword at `addr[1]`; w takes the full word.
- b/h sign-extend; bu/hu zero-extend.

FSM states: IDLE, WAIT, DONE.
- **IDLE:**
  - On a legal access: `mem_stall`=1. At the next edge, latch the bus outputs, set `bus_req`=1, clear the timeout counter, and go to WAIT.
- **WAIT:**
  - `mem_stall`=1 and `bus_req` is held.
  - When `bus_ack`=1: capture `bus_rdata` (loads), clear `bus_req`/`bus_we`/`bus_wstrb`, and go to DONE.
  - When the counter reaches `TIMEOUT`-1 without an ack: clear `bus_req`, set `mem_timeout`=1 with the captured word = 0, and go to DONE.
- **DONE:**
  - `mem_stall`=0 and `mem_rdata` is valid, so MEM/WB captures the result at the next edge.
  - Clear `mem_timeout` and go to IDLE unconditionally.
  - A new access becomes visible in IDLE one cycle later.
- `bus_ack` is ignored in IDLE and DONE.

## Timing
Reset (async, `rst`=1):
- State is IDLE.
- `bus_req`, `bus_we`, `bus_addr`, `bus_wstrb`, `bus_wdata`, captured word, counter and `mem_timeout` are all 0.
- The combinational outputs follow IDLE rules; with EX/MEM reset (inst=0) `mem_stall`=0, `mem_misalign`=0 and `mem_rdata`=0.

Latency: an access with its ack in the first WAIT cycle gives `mem_stall` for 2 cycles (IDLE, WAIT), then 1 DONE cycle. Each additional WAIT cycle adds one stall cycle.

Worst case: `TIMEOUT`+1 stall cycles.

Reset asserted mid-WAIT:
- `bus_req` drops asynchronously and the transaction is abandoned.
- An ack arriving after reset is ignored.

Back-to-back accesses: the request is re-issued one edge after the DONE→IDLE transition. `bus_req` is never high in two consecutive transactions without an intervening low cycle.

Bus outputs are stable throughout WAIT.

## Test plan
- **sw**: addr `0x100`, rD2 `0xDEADBEEF`, ack in the first WAIT cycle. Expect `bus_addr`=`0x100`, `wstrb`=`1111`, `wdata`=`0xDEADBEEF`, `mem_stall` high for exactly 2 cycles, `bus_req` for 1 cycle.
- **lb**: addr `0x203`, rdata `0x80FF1234`. Expect `mem_rdata`=`0xFFFFFF80`.
- **lbu**: same address and data as lb. Expect `0x00000080`.
- **lhu**: addr `0x202`. Expect `0x000080FF`.
- **sb**: addr `0x101`, rD2 `0x000000AB`. Expect `wstrb`=`0010`, `wdata`=`0xABABABAB`.
- **Misaligned lw**: addr `0x102`. Expect `mem_misalign`=1 and `mem_stall`=0, with no `bus_req` on any cycle.
- **Illegal-size store**: funct3 `011` with `mem_DRAM_we`=1. Expect `mem_misalign`=1 and no request.
- **Timeout**: `TIMEOUT`=4 and `bus_ack` held 0. Expect 5 stall cycles, `bus_req` dropped, DONE with `mem_timeout`=1 and `mem_rdata`=0, then IDLE.
- **Reset in WAIT**: assert `rst` during WAIT, then pulse `bus_ack` after release. Expect immediate IDLE with `bus_req`=0, `mem_stall`=0 for the reset EX/MEM contents, and the stray ack ignored.
- **Back-to-back**: load followed by store with immediate acks. Expect stall pattern 1,1,0,1,1,0 and the second `bus_req` only after the DONE cycle.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory access controller (req/ack bus, lane steering, load extension, stall)
// Ports:
//    clk, rst                 clock, asynchronous active-high reset
//    mem_inst                 instruction in MEM ([6:0] opcode, [14:12] funct3)
//    mem_alu_result           effective byte address
//    mem_rd2                  right-aligned store data
//    mem_dram_we              store enable
//    bus_req/we/addr/wstrb/wdata  registered request to the data RAM
//    bus_rdata, bus_ack       read word and one-cycle completion pulse
//    mem_stall                freezes upstream stages, bubbles MEM/WB
//    mem_rdata                extended load result, valid in DONE
//    mem_misalign             misaligned or illegal-size access
//    mem_timeout              high in DONE after an abandoned access
module mem_access_unit #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] mem_inst,
   input  logic [31:0] mem_alu_result,
   input  logic [31:0] mem_rD2,
   input  logic        mem_DRAM_we,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_wstrb,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ack,
   output logic        mem_stall,
   output logic [31:0] mem_rdata,
   output logic        mem_misalign,
   output logic        mem_timeout
);
   localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2;
   logic [1:0]  state;
   logic [7:0]  cnt;
   logic [31:0] word, wsh, wd, ext;
   logic [2:0]  f3;
   logic [1:0]  a;
   logic [3:0]  strb;
   logic [7:0]  rb;
   logic [15:0] rh;
   logic        is_load, access, legal, align_err, bad, good, unused_bits;
   assign unused_bits = ^{mem_inst[31:15], mem_inst[11:7]};
   assign f3 = mem_inst[14:12];
   assign a = mem_alu_result[1:0];
   assign is_load = !mem_DRAM_we && mem_inst[6:0] == 7'b0000011;
   assign access = mem_DRAM_we || is_load;
   assign legal = mem_DRAM_we ? f3 inside {3'b000, 3'b001, 3'b010}
                              : f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
   assign align_err = (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a != 2'b00);
   assign bad = access && (!legal || align_err);
   assign good = access && !bad;
   assign mem_misalign = bad;
   assign mem_stall = (state == IDLE && good) || state == WAIT;
   assign strb = f3[1:0] == 2'b00 ? 4'b0001 << a : f3[1:0] == 2'b01 ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
   assign wd = f3[1:0] == 2'b00 ? {4{mem_rD2[7:0]}} : f3[1:0] == 2'b01 ? {2{mem_rD2[15:0]}} : mem_rD2;
   // EX/MEM is frozen until DONE, so the live funct3/address still describe the captured word
   assign wsh = word >> {a, 3'b000};
   assign rb = wsh[7:0];
   assign rh = a[1] ? word[31:16] : word[15:0];
   assign ext = f3 == 3'b000 ? {{24{rb[7]}}, rb} :
                f3 == 3'b001 ? {{16{rh[15]}}, rh} :
                f3 == 3'b100 ? {24'd0, rb} :
                f3 == 3'b101 ? {16'd0, rh} : word;
   assign mem_rdata = state == DONE ? ext : 32'd0;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         bus_req <= 1'b0;
         bus_we <= 1'b0;
         bus_addr <= 32'd0;
         bus_wstrb <= 4'd0;
         bus_wdata <= 32'd0;
         word <= 32'd0;
         cnt <= 8'd0;
         mem_timeout <= 1'b0;
      end else begin
         case (state)
            IDLE: if (good) begin
               bus_req <= 1'b1;
               bus_we <= mem_DRAM_we;
               bus_addr <= {mem_alu_result[31:2], 2'b00};
               bus_wstrb <= mem_DRAM_we ? strb : 4'b0000;
               bus_wdata <= wd;
               cnt <= 8'd0;
               state <= WAIT;
            end
            WAIT: if (bus_ack || cnt == 8'(TIMEOUT - 1)) begin
               // an ack in the final wait cycle still completes normally
               bus_req <= 1'b0;
               bus_we <= 1'b0;
               bus_wstrb <= 4'b0000;
               word <= bus_ack ? bus_rdata : 32'd0;
               mem_timeout <= !bus_ack;
               state <= DONE;
            end else
               cnt <= cnt + 8'd1;
            default: begin
               mem_timeout <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule
